// File: rtl/tl_light_monitor.sv
// rtl/tl_light_monitor.sv - lamp-code decoder, transition checker and error statistics for the two-road traffic light
//
// Decodes the sampled lamp codes {LA,LB} back into the controller state,
// flags illegal lamp patterns and illegal state transitions, counts the
// length of each green phase and keeps sticky and saturating error statistics.
//
// Optional feature macro: TL_MON_GREEN_TIMEOUT_EN
//   defined   - err_timeout pulses when a green phase exceeds MAX_GREEN samples
//   undefined - err_timeout is tied to 0 and no timeout logic is built
//
// Parameters:
//   MAX_GREEN   longest legal green phase in samples (1..254), timeout build only
//   ERR_CNT_W   width of the saturating error counter
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   LA, LB       lamp codes: 00 green, 01 yellow, 10 red, 11 illegal
//   clr          synchronous clear of err_sticky / err_cnt
//   state_o      decoded controller state (S0..S3)
//   valid        last sample was a legal lamp pattern
//   err_pat      pulse: illegal lamp pattern
//   err_trans    pulse: illegal state transition
//   err_timeout  pulse: green held past MAX_GREEN
//   err_sticky   set by any error, cleared by reset or clr
//   err_cnt      saturating count of cycles carrying at least one error
//   green_cnt    consecutive samples in the current green state, saturating

module tl_light_monitor #(
    parameter int MAX_GREEN = 15,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           LA,
    input  logic [1:0]           LB,
    input  logic                 clr,
    output logic [1:0]           state_o,
    output logic                 valid,
    output logic                 err_pat,
    output logic                 err_trans,
    output logic                 err_timeout,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [7:0]           green_cnt
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } mon_state_t;

    localparam logic [ERR_CNT_W-1:0] LP_CNT_MAX = '1;

    mon_state_t           r_fsm;
    mon_state_t           w_fsm_nxt;

    logic                 w_legal;
    logic [1:0]           w_dec;
    logic                 w_trans_ok;
    logic                 w_is_green;

    logic [1:0]           w_state_nxt;
    logic                 w_valid_nxt;
    logic                 w_err_pat_nxt;
    logic                 w_err_trans_nxt;
    logic                 w_err_to_nxt;
    logic [7:0]           w_green_nxt;
    logic                 w_any_err;
    logic                 w_sticky_nxt;
    logic [ERR_CNT_W-1:0] w_cnt_nxt;

    // Pattern decode: only four of the sixteen lamp combinations are legal.
    always_comb begin
        w_legal = 1'b1;
        w_dec   = 2'd0;
        case ({LA, LB})
            4'b0010: w_dec = 2'd0;
            4'b0110: w_dec = 2'd1;
            4'b1000: w_dec = 2'd2;
            4'b1001: w_dec = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    // Transition table, checked against the previous state held in state_o.
    always_comb begin
        w_trans_ok = 1'b0;
        case (state_o)
            2'd0: w_trans_ok = (w_dec == 2'd0) || (w_dec == 2'd1);
            2'd1: w_trans_ok = (w_dec == 2'd2);
            2'd2: w_trans_ok = (w_dec == 2'd2) || (w_dec == 2'd3);
            2'd3: w_trans_ok = (w_dec == 2'd0);
            default: w_trans_ok = 1'b0;
        endcase
    end

    assign w_is_green = (w_dec == 2'd0) || (w_dec == 2'd2);

    // Tracker next-state and per-sample outputs.
    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_state_nxt     = state_o;
        w_valid_nxt     = 1'b0;
        w_err_pat_nxt   = 1'b0;
        w_err_trans_nxt = 1'b0;
        w_green_nxt     = 8'd0;
        if (!w_legal) begin
            // state_o keeps its last value; next legal sample reloads it unchecked.
            w_err_pat_nxt = 1'b1;
            w_fsm_nxt     = ST_INIT;
        end else begin
            w_state_nxt = w_dec;
            w_valid_nxt = 1'b1;
            w_fsm_nxt   = ST_TRACK;
            if ((r_fsm == ST_TRACK) && !w_trans_ok) begin
                // Flag it but still follow the lamps so tracking resynchronises.
                w_err_trans_nxt = 1'b1;
            end
            if (w_is_green) begin
                if ((r_fsm == ST_TRACK) && (state_o == w_dec)) begin
                    w_green_nxt = (green_cnt == 8'hFF) ? 8'hFF : green_cnt + 8'd1;
                end else begin
                    w_green_nxt = 8'd1;
                end
            end
        end
    end

`ifdef TL_MON_GREEN_TIMEOUT_EN
    localparam logic [7:0] LP_MAX_GREEN    = 8'(MAX_GREEN);
    localparam logic [7:0] LP_MAX_GREEN_P1 = 8'(MAX_GREEN + 1);

    // Armed again only once green_cnt has dropped to 0, so a resync straight
    // from one green to the other cannot produce a second pulse.
    logic r_to_armed;

    assign w_err_to_nxt = r_to_armed && (green_cnt == LP_MAX_GREEN) &&
                          (w_green_nxt == LP_MAX_GREEN_P1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_to_armed <= 1'b1;
        end else if (w_green_nxt == 8'd0) begin
            r_to_armed <= 1'b1;
        end else if (w_err_to_nxt) begin
            r_to_armed <= 1'b0;
        end
    end
`else
    assign w_err_to_nxt = 1'b0;
`endif

    // Error accounting: one count per erroneous cycle; a same-cycle error beats clr.
    assign w_any_err = w_err_pat_nxt | w_err_trans_nxt | w_err_to_nxt;

    always_comb begin
        w_sticky_nxt = err_sticky | w_any_err;
        w_cnt_nxt    = err_cnt;
        if (clr) begin
            w_sticky_nxt = w_any_err;
            w_cnt_nxt    = w_any_err ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (w_any_err && (err_cnt != LP_CNT_MAX)) begin
            w_cnt_nxt = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fsm       <= ST_INIT;
            state_o     <= 2'd0;
            valid       <= 1'b0;
            err_pat     <= 1'b0;
            err_trans   <= 1'b0;
            err_timeout <= 1'b0;
            err_sticky  <= 1'b0;
            err_cnt     <= '0;
            green_cnt   <= 8'd0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            state_o     <= w_state_nxt;
            valid       <= w_valid_nxt;
            err_pat     <= w_err_pat_nxt;
            err_trans   <= w_err_trans_nxt;
            err_timeout <= w_err_to_nxt;
            err_sticky  <= w_sticky_nxt;
            err_cnt     <= w_cnt_nxt;
            green_cnt   <= w_green_nxt;
        end
    end

endmodule

// File: tb/tb_tl_light_monitor.sv
// tb/tb_tl_light_monitor.sv - directed self-checking bench for tl_light_monitor

module tb_tl_light_monitor;

    localparam int MAX_GREEN = 4;
    localparam int ERR_CNT_W = 2;

    logic                 clk;
    logic                 reset_n;
    logic [1:0]           LA;
    logic [1:0]           LB;
    logic                 clr;
    logic [1:0]           state_o;
    logic                 valid;
    logic                 err_pat;
    logic                 err_trans;
    logic                 err_timeout;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [7:0]           green_cnt;

    int n_cmp;
    int n_bad;

    tl_light_monitor #(
        .MAX_GREEN (MAX_GREEN),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .LA          (LA),
        .LB          (LB),
        .clr         (clr),
        .state_o     (state_o),
        .valid       (valid),
        .err_pat     (err_pat),
        .err_trans   (err_trans),
        .err_timeout (err_timeout),
        .err_sticky  (err_sticky),
        .err_cnt     (err_cnt),
        .green_cnt   (green_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one sample and sample outputs 1 time unit after the capturing edge.
    task automatic step(input logic [3:0] pat, input logic c);
        {LA, LB} = pat;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".state_o"},     state_o,     0);
        check({tag, ".valid"},       valid,       0);
        check({tag, ".err_pat"},     err_pat,     0);
        check({tag, ".err_trans"},   err_trans,   0);
        check({tag, ".err_timeout"}, err_timeout, 0);
        check({tag, ".err_sticky"},  err_sticky,  0);
        check({tag, ".err_cnt"},     err_cnt,     0);
        check({tag, ".green_cnt"},   green_cnt,   0);
    endtask

    logic [3:0] seq_pat   [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0110,
                                  4'b1000, 4'b1000, 4'b1001, 4'b0010};
    int         seq_state [8] = '{0, 0, 0, 1, 2, 2, 3, 0};
    int         seq_green [8] = '{1, 2, 3, 0, 1, 2, 0, 1};
    int         sat_cnt   [5] = '{1, 2, 3, 3, 3};

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        LA      = 2'b00;
        LB      = 2'b10;
        clr     = 1'b0;

        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        check_idle("reset");

        // Normal cycle through all four states.
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(seq_pat[i], 1'b0);
            check($sformatf("seq%0d.state_o", i),   state_o,   seq_state[i]);
            check($sformatf("seq%0d.green_cnt", i), green_cnt, seq_green[i]);
            check($sformatf("seq%0d.valid", i),     valid,     1);
            check($sformatf("seq%0d.errs", i),
                  {err_pat, err_trans, err_timeout, err_sticky}, 0);
        end

        // Illegal transition S0 -> S2.
        step(4'b1000, 1'b0);
        check("s0s2.err_trans",  err_trans,  1);
        check("s0s2.state_o",    state_o,    2);
        check("s0s2.err_sticky", err_sticky, 1);
        check("s0s2.err_cnt",    err_cnt,    1);
        check("s0s2.green_cnt",  green_cnt,  1);
        step(4'b1000, 1'b0);
        check("s2s2.err_trans",  err_trans,  0);
        check("s2s2.green_cnt",  green_cnt,  2);
        check("s2s2.err_cnt",    err_cnt,    1);

        // Illegal pattern in TRACK, then INIT reload without transition check.
        step(4'b1110, 1'b0);
        check("pat.err_pat",   err_pat,   1);
        check("pat.valid",     valid,     0);
        check("pat.state_o",   state_o,   2);
        check("pat.green_cnt", green_cnt, 0);
        check("pat.err_cnt",   err_cnt,   2);
        step(4'b1001, 1'b0);
        check("reload.state_o",   state_o,   3);
        check("reload.err_trans", err_trans, 0);
        check("reload.err_pat",   err_pat,   0);
        check("reload.valid",     valid,     1);
        check("reload.err_cnt",   err_cnt,   2);

        // clr with a legal S3 -> S0 sample.
        step(4'b0010, 1'b1);
        check("clr.err_cnt",    err_cnt,    0);
        check("clr.err_sticky", err_sticky, 0);
        check("clr.state_o",    state_o,    0);
        check("clr.green_cnt",  green_cnt,  1);

        // Error counter saturation at 3.
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0);
            check($sformatf("sat%0d.err_cnt", i), err_cnt, sat_cnt[i]);
            check($sformatf("sat%0d.err_pat", i), err_pat, 1);
        end
        step(4'b1111, 1'b1);
        check("clr_err.err_cnt",    err_cnt,    1);
        check("clr_err.err_sticky", err_sticky, 1);

        // Long green phase: clr on the first sample, then hold S0 for 8 samples.
        for (int i = 0; i < 8; i++) begin
            step(4'b0010, (i == 0));
            check($sformatf("hold%0d.green_cnt", i), green_cnt, i + 1);
`ifdef TL_MON_GREEN_TIMEOUT_EN
            check($sformatf("hold%0d.err_timeout", i), err_timeout, (i == 4) ? 1 : 0);
`else
            check($sformatf("hold%0d.err_timeout", i), err_timeout, 0);
`endif
        end
`ifdef TL_MON_GREEN_TIMEOUT_EN
        check("hold.err_cnt",    err_cnt,    1);
        check("hold.err_sticky", err_sticky, 1);
`else
        check("hold.err_cnt",    err_cnt,    0);
        check("hold.err_sticky", err_sticky, 0);
`endif

        // Reset mid-S2 overrides clr and an illegal sample.
        step(4'b0110, 1'b0);
        check("pre_rst.state_o", state_o, 1);
        step(4'b1000, 1'b0);
        check("pre_rst2.state_o", state_o, 2);
        reset_n = 1'b0;
        step(4'b1111, 1'b1);
        check_idle("midrst");
        reset_n = 1'b1;
        step(4'b1001, 1'b0);
        check("post_rst.state_o",   state_o,   3);
        check("post_rst.err_trans", err_trans, 0);
        check("post_rst.valid",     valid,     1);
        check("post_rst.err_cnt",   err_cnt,   0);
        check("post_rst.green_cnt", green_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_light_monitor.md
# tl_light_monitor

Receive-side decoder and protocol checker for the two-road traffic light controller's lamp outputs. It samples the 2-bit lamp codes LA and LB, decodes them back into the controller state, and checks that every observed state transition is legal. It also tracks the length of each green phase and accumulates error statistics. It sits beside the controller in the top level, used both as a bench scoreboard and as a synthesizable run-time safety monitor.

## Interface
- MAX_GREEN, 15: longest legal green phase in cycles; valid range 1..254. Used only when the timeout check is compiled in.
- ERR_CNT_W, 4: width of the saturating error counter.

- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- LA  in  2  road A lamp code: 00 green, 01 yellow, 10 red, 11 illegal.
- LB  in  2  road B lamp code, same encoding as LA.
- clr  in  1  synchronous clear of err_sticky and err_cnt.
- state_o  out  2  decoded controller state, registered.
- valid  out  1  the last sample was a legal lamp pattern.
- err_pat  out  1  one-cycle pulse: the last sample was an illegal pattern.
- err_trans  out  1  one-cycle pulse: the last sample was an illegal transition.
- err_timeout  out  1  one-cycle pulse: green held past MAX_GREEN. Tied to 0 when the macro is off.
- err_sticky  out  1  set by any error; cleared by reset or clr.
- err_cnt  out  ERR_CNT_W  count of cycles carrying at least one error; saturating.
- green_cnt  out  8  consecutive samples in the current green state; saturates at 255.

## Operation
- Legal patterns map to states as follows:
  - {LA,LB}=00_10 is S0 (A green).
  - 01_10 is S1 (A yellow).
  - 10_00 is S2 (B green).
  - 10_01 is S3 (B yellow).
  - All other 12 patterns are illegal.
- The tracker FSM has two states:
  - INIT: no trusted previous state.
  - TRACK: the previous state is held in state_o.
- Reset enters INIT.
- In INIT:
  - A legal sample loads state_o, sets valid=1 and moves to TRACK. No transition check is made.
  - An illegal sample pulses err_pat, sets valid=0 and stays in INIT.
- In TRACK:
  - Legal transitions are S0→S0, S0→S1, S1→S2, S2→S2, S2→S3 and S3→S0.
  - A legal sample with a legal transition updates state_o.
  - A legal sample with any other transition pulses err_trans and still updates state_o, resynchronising to the new state.
  - An illegal sample pulses err_pat, sets valid=0, returns to INIT and holds state_o at its last value.
- green_cnt:
  - Becomes 1 on entering S0 or S2, including the first load from INIT.
  - Increments while the same green state repeats, saturating at 255.
  - Becomes 0 in S1, S3, or on an illegal sample.
- Error accounting:
  - Any error pulse in a cycle sets err_sticky and increments err_cnt by exactly 1, even if several errors occur in that cycle.
  - err_cnt saturates at 2^ERR_CNT_W−1.
- clr clears err_sticky and err_cnt.
  - If an error is flagged in the same cycle, the error wins: err_sticky=1, err_cnt=1.
  - clr does not affect tracking, state_o or green_cnt.

## Timing
- Every output is registered. Outputs after rising edge k reflect LA/LB sampled at edge k, so latency is 1 cycle.
- Error pulses last exactly 1 cycle per offending sample. Back-to-back offending samples give continuous high pulses.
- Reset values: state_o=00, valid=0, err_pat=0, err_trans=0, err_timeout=0, err_sticky=0, err_cnt=0, green_cnt=0, FSM in INIT.
- Reset asserted mid-operation takes effect at the next edge and overrides clr and all errors. The first sample after reset release is treated as in INIT.
- LA/LB are expected synchronous to clk. The block does no metastability handling.

## Configuration
- TL_MON_GREEN_TIMEOUT_EN defined: err_timeout pulses once, on the sample where green_cnt goes from MAX_GREEN to MAX_GREEN+1. It does not re-pulse until green_cnt has returned to 0 and re-entered green. The pulse feeds err_sticky and err_cnt.
- TL_MON_GREEN_TIMEOUT_EN undefined: err_timeout is constant 0 and no timeout logic is built. green_cnt is still present.

## Test plan
- Reset, then drive 00_10 ×3, 01_10, 10_00 ×2, 10_01, 00_10.
  - Required: state_o follows 0,0,0,1,2,2,3,0 one cycle late.
  - valid=1 throughout; no errors.
  - green_cnt reads 1,2,3,0,1,2,0,1.
- From S0, drive 10_00 (S0→S2).
  - Required: err_trans pulses once, state_o=2, err_sticky=1, err_cnt=1.
- Drive 11_10 in TRACK, then 10_01.
  - Required: err_pat=1 and valid=0 with state_o held.
  - The next sample loads state_o=3 with no err_trans, because INIT skips the transition check.
- With ERR_CNT_W=2, drive 5 consecutive illegal samples.
  - Required: err_cnt reads 1,2,3,3,3.
  - Then assert clr together with one more illegal sample: err_cnt=1, err_sticky=1.
- With TL_MON_GREEN_TIMEOUT_EN defined and MAX_GREEN=4, hold 00_10 for 8 cycles.
  - Required: err_timeout pulses only on the 5th sample; err_cnt=1.
  - Without the macro: no err_timeout and err_cnt=0.
- Assert reset_n=0 for one cycle mid-S2.
  - Required: all outputs return to reset values.
  - The next 10_01 loads S3 without err_trans.
